addsub_signed_serial: RTL and testbench

- Parametrised, multi-cycle signed two's-complement adder/subtractor.
- Processes DIGIT bits per clock, LSB digit first, under a start/busy/done handshake.
- Reports raw carry-out and signed overflow, with optional saturation.
- Successor to the single-cycle combinational signed adder/subtractor. Used where area matters more than latency; DIGIT = WIDTH gives a registered one-cycle unit.

---
 rtl/addsub_signed_serial_if.sv | 27 ++
 rtl/addsub_signed_serial.sv | 111 +++++++++++
 tb/tb_addsub_signed_serial.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/addsub_signed_serial_if.sv
// Request/response bundle for the digit-serial signed adder/subtractor.
// Handshake: start is sampled only while busy = 0; done pulses once, in the cycle result/cout/overflow change.
interface addsub_signed_serial_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             control;
    logic             sat_en;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;
    logic             state_dbg;

    modport master (
        output start, x, y, control, sat_en,
        input  busy, done, result, cout, overflow, state_dbg
    );

    modport slave (
        input  start, x, y, control, sat_en,
        output busy, done, result, cout, overflow, state_dbg
    );
endinterface

// File: rtl/addsub_signed_serial.sv
// Digit-serial signed adder/subtractor: DIGIT bits per clock, LSB digit first.
// Computes x + (y ^ {WIDTH{control}}) + control with raw cout/overflow and optional saturation.
module addsub_signed_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input logic                  clk,
    input logic                  rst_n,
    addsub_signed_serial_if.slave bus
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] xr;
    logic [WIDTH-1:0] yr;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             sat_r;
    logic             x_msb;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] result_r;
    logic             cout_r;
    logic             overflow_r;

    logic [DIGIT-1:0] xd;
    logic [DIGIT-1:0] yd;
    logic [DIGIT:0]   dsum;
    logic [WIDTH-1:0] acc_next;
    logic             c_msb;
    logic             ovf_next;
    logic [WIDTH-1:0] sat_val;

    // Operands shift right each cycle so the active digit is always at bit 0;
    // sum digits enter the accumulator from the top.
    always_comb begin
        xd       = xr[DIGIT-1:0];
        yd       = yr[DIGIT-1:0];
        dsum     = {1'b0, xd} + {1'b0, yd} + {{DIGIT{1'b0}}, carry};
        acc_next = acc >> DIGIT;
        acc_next[WIDTH-1 -: DIGIT] = dsum[DIGIT-1:0];
        c_msb    = xd[DIGIT-1] ^ yd[DIGIT-1] ^ dsum[DIGIT-1];
        ovf_next = c_msb ^ dsum[DIGIT];
        sat_val  = x_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            xr         <= '0;
            yr         <= '0;
            acc        <= '0;
            cnt        <= '0;
            carry      <= 1'b0;
            sat_r      <= 1'b0;
            x_msb      <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            result_r   <= '0;
            cout_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        xr     <= bus.x;
                        yr     <= bus.y ^ {WIDTH{bus.control}};
                        carry  <= bus.control;
                        sat_r  <= bus.sat_en;
                        x_msb  <= bus.x[WIDTH-1];
                        cnt    <= '0;
                        acc    <= '0;
                        busy_r <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    xr    <= xr >> DIGIT;
                    yr    <= yr >> DIGIT;
                    acc   <= acc_next;
                    carry <= dsum[DIGIT];
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(NDIG - 1)) begin
                        cout_r     <= dsum[DIGIT];
                        overflow_r <= ovf_next;
                        result_r   <= (sat_r && ovf_next) ? sat_val : acc_next;
                        busy_r     <= 1'b0;
                        done_r     <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.result    = result_r;
    assign bus.cout      = cout_r;
    assign bus.overflow  = overflow_r;
    assign bus.state_dbg = (state == RUN);
endmodule

// File: tb/tb_addsub_signed_serial.sv
// Directed and randomised checks of addsub_signed_serial (WIDTH = 8, DIGIT = 2).
module tb_addsub_signed_serial;
  localparam int W    = 8;
  localparam int D    = 2;
  localparam int NDIG = W / D;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  logic [W+1:0] exp_q[$];  // {cout, overflow, result}

  addsub_signed_serial_if #(.WIDTH(W)) bus ();

  addsub_signed_serial #(.WIDTH(W), .DIGIT(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic ctl, input logic sat);
    logic [W-1:0] bb;
    logic [W:0]   full;
    logic         ovf;
    logic [W-1:0] r;
    bb   = ctl ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, ctl};
    ovf  = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
    r    = full[W-1:0];
    if (sat && ovf) r = a[W-1] ? 8'h80 : 8'h7F;
    return {full[W], ovf, r};
  endfunction

  // driver: present a request for one edge, then check it was taken
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ctl, input logic sat);
    @(negedge clk);
    bus.x       = a;
    bus.y       = b;
    bus.control = ctl;
    bus.sat_en  = sat;
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("busy_on_accept", {31'd0, bus.busy}, 32'd1);
  endtask

  // wait for done (bounded), check latency/busy, then score against exp_q
  task automatic wait_done(input string tag, input int exp_lat, input bit pulse_chk,
                           input bit noise);
    int n;
    int busy_low;
    logic [W+1:0] e;
    n = 0;
    busy_low = 0;
    do begin
      if (noise) begin
        @(negedge clk);
        bus.start = 1'($urandom_range(0, 1));
        bus.x     = W'($urandom_range(0, 255));
        bus.y     = W'($urandom_range(0, 255));
      end
      @(posedge clk);
      #1;
      n++;
      if (!bus.done && !bus.busy) busy_low++;
    end while (!bus.done && n < 50);
    bus.start = 1'b0;
    check({tag, "_lat"}, n, exp_lat);
    check({tag, "_busy_run"}, busy_low, 0);
    check({tag, "_busy_done"}, {31'd0, bus.busy}, 32'd0);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_result"}, {24'd0, bus.result}, {24'd0, e[W-1:0]});
      check({tag, "_cout"}, {31'd0, bus.cout}, {31'd0, e[W+1]});
      check({tag, "_ovf"}, {31'd0, bus.overflow}, {31'd0, e[W]});
    end else begin
      check({tag, "_exp_q_empty"}, 32'd1, 32'd0);
    end
    if (pulse_chk) begin
      @(posedge clk);
      #1;
      check({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
      check({tag, "_idle_after"}, {31'd0, bus.state_dbg}, 32'd0);
    end
  endtask

  task automatic run_directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic ctl, input logic sat, input logic [W-1:0] r,
                              input logic c, input logic o);
    exp_q.push_back({c, o, r});
    start_op(a, b, ctl, sat);
    wait_done(tag, NDIG, 1'b1, 1'b0);
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.x       = '0;
    bus.y       = '0;
    bus.control = 1'b0;
    bus.sat_en  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_result", {24'd0, bus.result}, 32'd0);
    check("rst_cout", {31'd0, bus.cout}, 32'd0);
    check("rst_ovf", {31'd0, bus.overflow}, 32'd0);
    check("rst_state", {31'd0, bus.state_dbg}, 32'd0);

    // hand-computed vectors
    run_directed("sub_5_3",      8'h05, 8'h03, 1'b1, 1'b0, 8'h02, 1'b1, 1'b0);
    run_directed("add_ovf",      8'h64, 8'h32, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);
    run_directed("add_ovf_sat",  8'h64, 8'h32, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1);
    run_directed("sub_min_sat",  8'h80, 8'h01, 1'b1, 1'b1, 8'h80, 1'b1, 1'b1);
    run_directed("sub_min_raw",  8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1);
    run_directed("sub_zero",     8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    run_directed("add_wrap",     8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    run_directed("sub_neg",      8'h03, 8'h05, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);

    // start during RUN is ignored
    exp_q.push_back({1'b0, 1'b0, 8'h30});
    start_op(8'h10, 8'h20, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.x       = 8'h55;
    bus.y       = 8'h11;
    bus.control = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done("ignore_start", NDIG - 2, 1'b1, 1'b0);

    // back-to-back: start held in the done cycle
    exp_q.push_back({1'b1, 1'b1, 8'h7F});
    start_op(8'h80, 8'h01, 1'b1, 1'b0);
    wait_done("b2b_first", NDIG, 1'b0, 1'b0);
    exp_q.push_back({1'b0, 1'b0, 8'h46});
    start_op(8'h21, 8'h25, 1'b0, 1'b0);
    wait_done("b2b_second", NDIG, 1'b1, 1'b0);

    // asynchronous reset in the second RUN cycle
    start_op(8'h12, 8'h34, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_result", {24'd0, bus.result}, 32'd0);
    check("arst_busy", {31'd0, bus.busy}, 32'd0);
    check("arst_done", {31'd0, bus.done}, 32'd0);
    check("arst_cout", {31'd0, bus.cout}, 32'd0);
    check("arst_state", {31'd0, bus.state_dbg}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("arst_no_done", {31'd0, bus.done}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_directed("post_rst_add", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);

    // random run against the behavioural model, with spurious starts while busy
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic ctl;
      logic sat;
      a   = W'($urandom_range(0, 255));
      b   = W'($urandom_range(0, 255));
      ctl = 1'($urandom_range(0, 1));
      sat = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      exp_q.push_back(model(a, b, ctl, sat));
      start_op(a, b, ctl, sat);
      wait_done("rand", NDIG, 1'b0, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
